// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_pkg
// Purpose : Shared types and constants for the data-memory arbiter.
//           arb_state_t - arbiter FSM state encoding
//           master_id_t - master index (0 = core data port, 1 = debug/loader)
//           PERIPH_*    - memory-mapped peripheral addresses (used by benches;
//                         the arbiter passes them through without decoding)
// Revision: 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  localparam logic [31:0] PERIPH_SW_ADDR  = 32'hC000_0000;
  localparam logic [31:0] PERIPH_LED_ADDR = 32'hC000_0004;

  // Grant statistics counters (only present with DMEM_ARB_STATS_EN)
  localparam int                  STATS_W   = 16;
  localparam logic [STATS_W-1:0]  STATS_MAX = 16'hFFFF;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arb_rr
// Purpose : Combinational round-robin winner selection for two masters.
//           A lone requester always wins; on a tie the master that was NOT
//           granted last wins.
// Ports   : req      in  2  {m1_req, m0_req}
//           last_gnt in  1  master granted most recently
//           any_req  out 1  at least one request pending
//           winner   out 1  selected master (valid when any_req = 1)
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_gnt,
  output logic       any_req,
  output master_id_t winner
);

  always_comb begin
    any_req = |req;
    winner  = M0;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = ~last_gnt;
      default: winner = M0;
    endcase
  end

endmodule : dmem_arb_rr
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Shares the single-port data memory (RAM + memory-mapped
//           switches/LEDs) between m0 (core data port) and m1 (debug/loader).
//           Round-robin arbitration, req/ack handshake, one access per grant.
//           Each grant runs IDLE -> ACCESS -> RESP; the ack is a one-cycle
//           pulse in RESP carrying the read data sampled at the end of ACCESS.
// Ports   : clk, reset              clock, async active-high reset
//           mN_req/we/addr/wdata    master N request side (N = 0, 1)
//           mN_rdata/ack            master N response side
//           mem_we/a/wd, mem_rd     data-memory interface (combinational rd)
//           gnt_cnt0/1              grant counters (DMEM_ARB_STATS_EN only)
// Config  : DMEM_ARB_STATS_EN - adds saturating 16-bit per-master grant
//           counters cleared by reset.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               reset,
  // master 0
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [AW-1:0]      m0_addr,
  input  logic [DW-1:0]      m0_wdata,
  output logic [DW-1:0]      m0_rdata,
  output logic               m0_ack,
  // master 1
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [AW-1:0]      m1_addr,
  input  logic [DW-1:0]      m1_wdata,
  output logic [DW-1:0]      m1_rdata,
  output logic               m1_ack,
`ifdef DMEM_ARB_STATS_EN
  output logic [STATS_W-1:0] gnt_cnt0,
  output logic [STATS_W-1:0] gnt_cnt1,
`endif
  // data memory
  output logic               mem_we,
  output logic [AW-1:0]      mem_a,
  output logic [DW-1:0]      mem_wd,
  input  logic [DW-1:0]      mem_rd
);

  arb_state_t state;
  master_id_t last_gnt;
  master_id_t cur_id;     // master owning the access in flight
  logic       any_req;
  master_id_t winner;
  logic       grant;

  dmem_arb_rr u_rr (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt),
    .any_req  (any_req),
    .winner   (winner)
  );

  assign grant = (state == IDLE) && any_req;

  // mem_a/mem_wd double as the latched address/data of the current grant,
  // so changes on the master side after grant never reach the memory.
  // mem_we is only ever high during ACCESS, and an asynchronous reset
  // drops it immediately, aborting a write before the memory commits it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_gnt <= M1;
      cur_id   <= M0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_wd   <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= ACCESS;
            last_gnt <= winner;
            cur_id   <= winner;
            if (winner == M1) begin
              mem_we <= m1_we;
              mem_a  <= m1_addr;
              mem_wd <= m1_wdata;
            end else begin
              mem_we <= m0_we;
              mem_a  <= m0_addr;
              mem_wd <= m0_wdata;
            end
          end
        end
        ACCESS: begin
          // Memory commits the write / presents read data this cycle;
          // writes return zero read data.
          state <= RESP;
          if (cur_id == M1) begin
            m1_ack   <= 1'b1;
            m1_rdata <= mem_we ? '0 : mem_rd;
          end else begin
            m0_ack   <= 1'b1;
            m0_rdata <= mem_we ? '0 : mem_rd;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (grant) begin
      if (winner == M1) begin
        if (gnt_cnt1 != STATS_MAX) gnt_cnt1 <= gnt_cnt1 + 1'b1;
      end else begin
        if (gnt_cnt0 != STATS_MAX) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      end
    end
  end
`endif

endmodule : dmem_arbiter
`default_nettype wire
